// File: rtl/eh2_pkg.sv
// rtl/eh2_pkg.sv - shared types for the LSU clock-control sequencer
package eh2_pkg;

  localparam int HYST_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } eh2_lsu_halt_state_t;

endpackage

// File: rtl/eh2_lsu_clk_ctl_if.sv
// rtl/eh2_lsu_clk_ctl_if.sv - LSU clock-control signal bundle (slave = sequencer side)
interface eh2_lsu_clk_ctl_if #(
  parameter int NUM_THREADS = 2,
  parameter int RATIO_W     = 3
);

  logic                   clk_override;
  logic [RATIO_W-1:0]     bus_ratio;
  logic                   lsu_active;
  logic [NUM_THREADS-1:0] lsu_thr_active;
  logic                   dma_dccm_req;
  logic [NUM_THREADS-1:0] stbuf_empty;
  logic [NUM_THREADS-1:0] bus_buffer_empty;
  logic [NUM_THREADS-1:0] halt_req;
  logic [NUM_THREADS-1:0] halt_ack;
  logic                   lsu_bus_clk_en;
  logic                   lsu_free_clken;
  logic                   lsu_idle;

  modport slave (
    input  clk_override, bus_ratio, lsu_active, lsu_thr_active, dma_dccm_req,
           stbuf_empty, bus_buffer_empty, halt_req,
    output halt_ack, lsu_bus_clk_en, lsu_free_clken, lsu_idle
  );

  modport master (
    output clk_override, bus_ratio, lsu_active, lsu_thr_active, dma_dccm_req,
           stbuf_empty, bus_buffer_empty, halt_req,
    input  halt_ack, lsu_bus_clk_en, lsu_free_clken, lsu_idle
  );

endinterface

// File: rtl/eh2_lsu_halt_fsm.sv
// rtl/eh2_lsu_halt_fsm.sv - per-thread halt/drain handshake
module eh2_lsu_halt_fsm
  import eh2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic halt_req,
  input  logic drained,
  output logic halt_ack,
  output logic halted
);

  eh2_lsu_halt_state_t state_d, state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping the request always wins, even in the cycle the drain completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (halt_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!halt_req)    state_d = IDLE;
        else if (drained) state_d = HALTED;
      end
      HALTED: begin
        if (!halt_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    halted   = (state_q == HALTED);
    halt_ack = (state_q == HALTED);
  end

endmodule

// File: rtl/rvdffs.sv
// rtl/rvdffs.sv - enabled flop with synchronous active-high reset
module rvdffs #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (en) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/eh2_lsu_clk_ctl.sv
// rtl/eh2_lsu_clk_ctl.sv - bus clock enable, free-clock hysteresis and per-thread halt sequencing
module eh2_lsu_clk_ctl
  import eh2_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int RATIO_W     = 3,
  parameter int HYST_CNT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  eh2_lsu_clk_ctl_if.slave  lsu_if
);

  localparam logic [HYST_W-1:0] HYST_INIT = HYST_W'(HYST_CNT);

  logic [RATIO_W-1:0]     ratio_d, ratio_q;
  logic [RATIO_W-1:0]     bcnt_d, bcnt_q;
  logic [HYST_W-1:0]      hyst_d, hyst_q;
  logic                   idle_d, idle_q;
  logic                   bus_edge;
  logic                   busy;
  logic [NUM_THREADS-1:0] drained;
  logic [NUM_THREADS-1:0] halted;
  logic [NUM_THREADS-1:0] halt_ack;

  // The new ratio is only picked up on a bus-cycle boundary so no runt pulse is produced.
  always_comb begin
    bus_edge = (bcnt_q == ratio_q);
    ratio_d  = lsu_if.bus_ratio;
    bcnt_d   = bus_edge ? '0 : bcnt_q + 1'b1;
  end

  rvdffs #(.WIDTH(RATIO_W)) u_ratio_ff (
    .clk  (clk),
    .rst  (rst),
    .en   (bus_edge),
    .din  (ratio_d),
    .dout (ratio_q)
  );

  rvdffs #(.WIDTH(RATIO_W)) u_bcnt_ff (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .din  (bcnt_d),
    .dout (bcnt_q)
  );

  always_comb begin
    busy = lsu_if.lsu_active | lsu_if.dma_dccm_req |
           ~&lsu_if.stbuf_empty | ~&lsu_if.bus_buffer_empty;
    if (busy) begin
      hyst_d = HYST_INIT;
    end else if (hyst_q != '0) begin
      hyst_d = hyst_q - 1'b1;
    end else begin
      hyst_d = '0;
    end
    idle_d = (&halted) & ~busy & (hyst_q == '0);
  end

  rvdffs #(.WIDTH(HYST_W), .RESET_VAL(HYST_INIT)) u_hyst_ff (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .din  (hyst_d),
    .dout (hyst_q)
  );

  rvdffs #(.WIDTH(1)) u_idle_ff (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .din  (idle_d),
    .dout (idle_q)
  );

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
    assign drained[g] = lsu_if.stbuf_empty[g] & lsu_if.bus_buffer_empty[g] &
                        ~lsu_if.lsu_thr_active[g];

    eh2_lsu_halt_fsm u_fsm (
      .clk      (clk),
      .rst      (rst),
      .halt_req (lsu_if.halt_req[g]),
      .drained  (drained[g]),
      .halt_ack (halt_ack[g]),
      .halted   (halted[g])
    );
  end

  assign lsu_if.halt_ack       = halt_ack;
  assign lsu_if.lsu_bus_clk_en = bus_edge | lsu_if.clk_override;
  assign lsu_if.lsu_free_clken = busy | (hyst_q != '0) | lsu_if.clk_override;
  assign lsu_if.lsu_idle       = idle_q;

endmodule

// File: tb/tb_eh2_lsu_clk_ctl.sv
// tb/tb_eh2_lsu_clk_ctl.sv - self-checking bench for eh2_lsu_clk_ctl
module tb_eh2_lsu_clk_ctl;

  localparam int NT = 2;
  localparam int RW = 3;
  localparam int HC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eh2_lsu_clk_ctl_if #(.NUM_THREADS(NT), .RATIO_W(RW)) ifc ();

  eh2_lsu_clk_ctl #(.NUM_THREADS(NT), .RATIO_W(RW), .HYST_CNT(HC)) dut (
    .clk    (clk),
    .rst    (rst),
    .lsu_if (ifc)
  );

  int checks   = 0;
  int failures = 0;

  logic          d_rst;
  logic          d_ovr;
  logic [RW-1:0] d_ratio;
  logic          d_act;
  logic          d_dma;
  logic [NT-1:0] d_thr, d_stb, d_bb, d_req;

  // Reference model: pulse schedule, time since last busy, and per-thread request runs.
  int            cyc;
  int            next_pulse;
  int            last_busy;
  logic [NT-1:0] in_run, got, ack_now;
  logic          idle_now;
  logic          busy_m;
  logic          exp_en, exp_free, exp_idle;
  logic [NT-1:0] exp_ack;

  task automatic apply();
    @(posedge clk);
    #1;
    rst                  = d_rst;
    ifc.clk_override     = d_ovr;
    ifc.bus_ratio        = d_ratio;
    ifc.lsu_active       = d_act;
    ifc.dma_dccm_req     = d_dma;
    ifc.lsu_thr_active   = d_thr;
    ifc.stbuf_empty      = d_stb;
    ifc.bus_buffer_empty = d_bb;
    ifc.halt_req         = d_req;
  endtask

  task automatic model_reset();
    cyc        = 0;
    next_pulse = 0;
    last_busy  = -1;
    in_run     = '0;
    got        = '0;
    ack_now    = '0;
    idle_now   = 1'b0;
  endtask

  task automatic set_quiet();
    d_rst = 1'b0; d_ovr = 1'b0; d_ratio = '0; d_act = 1'b0; d_dma = 1'b0;
    d_thr = '0; d_stb = '1; d_bb = '1; d_req = '0;
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    apply();
    apply();
    model_reset();
    d_rst = 1'b0;
  endtask

  task automatic step_begin();
    apply();
    @(negedge clk);
    busy_m   = d_act | d_dma | (d_stb != '1) | (d_bb != '1);
    exp_en   = (cyc == next_pulse) | d_ovr;
    exp_free = busy_m | ((cyc - last_busy) <= HC) | d_ovr;
    exp_ack  = ack_now;
    exp_idle = idle_now;
  endtask

  task automatic step_end();
    if (cyc == next_pulse) next_pulse = cyc + int'(d_ratio) + 1;
    idle_now = (&ack_now) & ~busy_m & ((cyc - last_busy) > HC);
    if (busy_m) last_busy = cyc;
    for (int i = 0; i < NT; i++) begin
      if (!d_req[i]) begin
        in_run[i] = 1'b0;
        got[i]    = 1'b0;
      end else if (!in_run[i]) begin
        in_run[i] = 1'b1;
        got[i]    = 1'b0;
      end else if (d_stb[i] && d_bb[i] && !d_thr[i]) begin
        got[i] = 1'b1;
      end
      ack_now[i] = in_run[i] & got[i];
    end
    cyc++;
  endtask

  task automatic test_reset();
    set_quiet();
    do_reset();
    step_begin();
    checks++; if (ifc.halt_ack !== '0) begin failures++; $display("FAIL reset_ack got=%0h want=0", ifc.halt_ack); end
    checks++; if (ifc.lsu_idle !== 1'b0) begin failures++; $display("FAIL reset_idle got=%0b want=0", ifc.lsu_idle); end
    checks++; if (ifc.lsu_bus_clk_en !== 1'b1) begin failures++; $display("FAIL reset_bus_en got=%0b want=1", ifc.lsu_bus_clk_en); end
    checks++; if (ifc.lsu_free_clken !== 1'b1) begin failures++; $display("FAIL reset_free got=%0b want=1", ifc.lsu_free_clken); end
    step_end();
  endtask

  task automatic test_ratio_sweep();
    logic want;
    set_quiet();
    d_ratio = 3'd2;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c == 4) d_ratio = 3'd0;
      step_begin();
      want = (c == 0) || (c == 3) || (c >= 6);
      checks++;
      if (ifc.lsu_bus_clk_en !== want) begin
        failures++; $display("FAIL ratio_sweep cyc=%0d got=%0b want=%0b", c, ifc.lsu_bus_clk_en, want);
      end
      step_end();
    end
  endtask

  task automatic test_hysteresis();
    logic want;
    set_quiet();
    do_reset();
    for (int c = 0; c < 21; c++) begin
      d_act = (c >= 10) && (c <= 12);
      step_begin();
      want = (c <= 3) || ((c >= 10) && (c <= 16));
      checks++;
      if (ifc.lsu_free_clken !== want) begin
        failures++; $display("FAIL hysteresis cyc=%0d got=%0b want=%0b", c, ifc.lsu_free_clken, want);
      end
      step_end();
    end
  endtask

  task automatic test_drain();
    logic [NT-1:0] want;
    set_quiet();
    d_stb[0] = 1'b0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      d_stb[0] = (c >= 20);
      d_req[0] = (c >= 5);
      step_begin();
      want    = '0;
      want[0] = (c >= 21);
      checks++;
      if (ifc.halt_ack !== want) begin
        failures++; $display("FAIL drain cyc=%0d got=%0h want=%0h", c, ifc.halt_ack, want);
      end
      step_end();
    end
  endtask

  task automatic test_abort();
    logic [NT-1:0] want;
    set_quiet();
    d_bb[1] = 1'b0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      d_bb[1]  = (c >= 8);
      d_req[1] = ((c >= 5) && (c <= 7)) || ((c >= 9) && (c <= 14)) || (c == 20);
      step_begin();
      want    = '0;
      want[1] = (c >= 11) && (c <= 15);
      checks++;
      if (ifc.halt_ack !== want) begin
        failures++; $display("FAIL abort cyc=%0d got=%0h want=%0h", c, ifc.halt_ack, want);
      end
      step_end();
    end
  endtask

  task automatic test_idle();
    logic want;
    set_quiet();
    d_req = '1;
    do_reset();
    for (int c = 0; c < 21; c++) begin
      d_dma = (c == 10);
      step_begin();
      want = ((c >= 5) && (c <= 10)) || (c >= 16);
      checks++;
      if (ifc.lsu_idle !== want) begin
        failures++; $display("FAIL idle cyc=%0d got=%0b want=%0b", c, ifc.lsu_idle, want);
      end
      if (c == 11) begin
        checks++;
        if (ifc.lsu_free_clken !== 1'b1) begin
          failures++; $display("FAIL idle_hyst_reload cyc=%0d got=%0b want=1", c, ifc.lsu_free_clken);
        end
      end
      step_end();
    end
  endtask

  task automatic test_reset_mid();
    set_quiet();
    d_req   = '1;
    d_ratio = 3'd5;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      d_rst = (c == 30);
      step_begin();
      if (c == 30) begin
        checks++;
        if (ifc.halt_ack !== '1) begin
          failures++; $display("FAIL pre_reset_ack got=%0h want=%0h", ifc.halt_ack, {NT{1'b1}});
        end
        model_reset();
      end else begin
        step_end();
      end
    end
    d_rst = 1'b0;
    step_begin();
    checks++; if (ifc.halt_ack !== '0) begin failures++; $display("FAIL midreset_ack got=%0h want=0", ifc.halt_ack); end
    checks++; if (ifc.lsu_free_clken !== 1'b1) begin failures++; $display("FAIL midreset_free got=%0b want=1", ifc.lsu_free_clken); end
    checks++; if (ifc.lsu_bus_clk_en !== 1'b1) begin failures++; $display("FAIL midreset_bus_en got=%0b want=1", ifc.lsu_bus_clk_en); end
    checks++; if (ifc.lsu_idle !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%0b want=0", ifc.lsu_idle); end
    step_end();
  endtask

  task automatic test_random();
    logic calm;
    set_quiet();
    do_reset();
    calm = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) calm = ~calm;
      if ($urandom % 40 == 0) d_ratio = RW'($urandom);
      d_ovr = ($urandom % 16 == 0);
      d_act = calm ? ($urandom % 40 == 0) : ($urandom % 4 == 0);
      d_dma = calm ? 1'b0 : ($urandom % 8 == 0);
      for (int i = 0; i < NT; i++) begin
        d_stb[i] = calm ? ($urandom % 32 != 0) : ($urandom % 4 != 0);
        d_bb[i]  = calm ? ($urandom % 32 != 0) : ($urandom % 4 != 0);
        if ($urandom % 10 == 0) d_req[i] = ~d_req[i];
        d_thr[i] = ack_now[i] ? 1'b0 : ($urandom % 4 == 0);
      end
      step_begin();
      checks++;
      if (ifc.lsu_bus_clk_en !== exp_en) begin
        failures++; $display("FAIL rand_bus_en cyc=%0d got=%0b want=%0b", c, ifc.lsu_bus_clk_en, exp_en);
      end
      checks++;
      if (ifc.lsu_free_clken !== exp_free) begin
        failures++; $display("FAIL rand_free cyc=%0d got=%0b want=%0b", c, ifc.lsu_free_clken, exp_free);
      end
      checks++;
      if (ifc.halt_ack !== exp_ack) begin
        failures++; $display("FAIL rand_ack cyc=%0d got=%0h want=%0h", c, ifc.halt_ack, exp_ack);
      end
      checks++;
      if (ifc.lsu_idle !== exp_idle) begin
        failures++; $display("FAIL rand_idle cyc=%0d got=%0b want=%0b", c, ifc.lsu_idle, exp_idle);
      end
      checks++;
      if ((ifc.halt_ack & d_thr) !== '0) begin
        failures++; $display("FAIL rand_halted_activity cyc=%0d got=%0h want=0", c, ifc.halt_ack & d_thr);
      end
      step_end();
    end
  endtask

  initial begin
    set_quiet();
    apply();
    test_reset();
    test_ratio_sweep();
    test_hysteresis();
    test_drain();
    test_abort();
    test_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
